// File: rtl/fp_divider_seq.sv
// fp_divider_seq: multi-cycle IEEE-754 divider (restoring radix-2), optional RNE via FP_DIV_RNE_EN
module fp_divider_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS = 2**(EXP_W-1)-1,
  localparam int W = 1+EXP_W+MAN_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   exc_flags,
  output logic         busy
);
  localparam int CW = $clog2(MAN_W+3);
  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'(2**EXP_W-1);
  localparam logic [W-1:0] QNAN = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, CLASSIFY, DIVIDE, ROUND, DONE} state_t;
  state_t state, state_n;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic s_in, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sp;
  logic [W-1:0] sp_res, sp_res_q;
  logic [4:0] sp_flags, sp_flags_q;
  logic sign_q;
  logic signed [EXP_W+1:0] e_q, e1, e2;
  logic [MAN_W:0] mb_q, diff, man;
  logic [MAN_W+1:0] rem_q, sum;
  logic [MAN_W+2:0] q_q, nq;
  logic [CW-1:0] cnt_q;
  logic ge, top, guard, st, inc, carry, ovf, unf;
  logic [MAN_W-1:0] frac;
  logic [W-1:0] ovf_res, rnd_res;
  assign {ea, fa} = a_operand[W-2:0];
  assign {eb, fb} = b_operand[W-2:0];
  assign s_in = a_operand[W-1] ^ b_operand[W-1];
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign a_inf = ea == E_ONES && fa == '0;
  assign b_inf = eb == E_ONES && fb == '0;
  assign a_nan = ea == E_ONES && fa != '0;
  assign b_nan = eb == E_ONES && fb != '0;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  // special-operand result, decided from the raw operands at accept
  always_comb begin
    sp = 1'b1;
    sp_res = '0;
    sp_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = QNAN;
      sp_flags = 5'b10000;
    end else if (a_inf) sp_res = {s_in, E_ONES, {MAN_W{1'b0}}};
    else if (b_zero) begin
      sp_res = {s_in, E_ONES, {MAN_W{1'b0}}};
      sp_flags = 5'b01000;
    end else if (b_inf || a_zero) sp_res = {s_in, {(W-1){1'b0}}};
    else sp = 1'b0;
  end
  assign ge = rem_q >= {1'b0, mb_q};
  assign diff = rem_q[MAN_W:0] - (ge ? mb_q : '0);
  assign top = q_q[MAN_W+2];
  assign nq = top ? q_q : q_q << 1;
  assign e1 = top ? e_q : e_q - (EXP_W+2)'(1);
  assign man = nq[MAN_W+2:2];
  assign guard = nq[1];
  assign st = (rem_q != '0) | nq[0];
`ifdef FP_DIV_RNE_EN
  assign inc = guard & (st | man[0]);
  assign ovf_res = {sign_q, E_ONES, {MAN_W{1'b0}}};
`else
  assign inc = 1'b0;
  assign ovf_res = {sign_q, E_ONES - 1'b1, {MAN_W{1'b1}}};
`endif
  assign sum = {1'b0, man} + (MAN_W+2)'(inc);
  assign carry = sum[MAN_W+1];
  assign frac = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign e2 = e1 + (EXP_W+2)'(carry);
  assign ovf = !e2[EXP_W+1] && e2 >= E_MAX;
  assign unf = e2[EXP_W+1] || e2 == '0;
  assign rnd_res = ovf ? ovf_res : unf ? {sign_q, {(W-1){1'b0}}} : {sign_q, e2[EXP_W-1:0], frac};
  // state register
  always_ff @(posedge CLK) state <= RESET ? IDLE : state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = sp ? CLASSIFY : DIVIDE;
      CLASSIFY: state_n = DONE;
      DIVIDE: if (cnt_q == '0) state_n = ROUND;
      ROUND: state_n = DONE;
      DONE: if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // operand capture, quotient iteration and result/flag registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      result <= '0;
      exc_flags <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        sp_res_q <= sp_res;
        sp_flags_q <= sp_flags;
        sign_q <= s_in;
        e_q <= (EXP_W+2)'(ea) - (EXP_W+2)'(eb) + (EXP_W+2)'(BIAS);
        rem_q <= {2'b01, fa};
        mb_q <= {1'b1, fb};
        q_q <= '0;
        cnt_q <= CW'(MAN_W+2);
      end
      if (state == DIVIDE) begin
        q_q <= {q_q[MAN_W+1:0], ge};
        rem_q <= {diff, 1'b0};
        cnt_q <= cnt_q - 1'b1;
      end
      if (state == CLASSIFY) begin
        result <= sp_res_q;
        exc_flags <= sp_flags_q;
      end
      if (state == ROUND) begin
        result <= rnd_res;
        exc_flags <= {2'b00, ovf, unf, guard | st | ovf | unf};
      end
      out_valid <= state == DONE && !(out_valid && out_ready);
    end
  end
endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq: randomized and directed checks of fp_divider_seq against an integer reference model
module tb_fp_divider_seq;
  logic CLK = 1'b0, RESET = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a_operand = '0, b_operand = '0;
  logic in_ready, out_valid, busy;
  logic [31:0] result;
  logic [4:0] exc_flags;
  int checks = 0, errors = 0;

  fp_divider_seq dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .exc_flags(exc_flags), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] r,
                       output logic [4:0] f, output bit sp);
    bit s, az, bz, ai, bi, an, bn, g, st;
    int ea, eb, e;
    longint num, den, q, rem, m;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = ea == 0; bz = eb == 0;
    ai = ea == 255 && a[22:0] == 0; bi = eb == 255 && b[22:0] == 0;
    an = ea == 255 && a[22:0] != 0; bn = eb == 255 && b[22:0] != 0;
    sp = 1; f = 0; r = 0;
    if (an || bn || (az && bz) || (ai && bi)) begin r = 32'h7FC00000; f = 5'b10000; return; end
    if (ai) begin r = {s, 8'hFF, 23'h0}; return; end
    if (bz) begin r = {s, 8'hFF, 23'h0}; f = 5'b01000; return; end
    if (bi || az) begin r = {s, 31'h0}; return; end
    sp = 0;
    num = longint'({1'b1, a[22:0]}) << 25;
    den = longint'({1'b1, b[22:0]});
    q = num / den;
    rem = num % den;
    e = ea - eb + 127;
    if (q >= (longint'(1) << 25)) begin
      m = q >> 2; g = q[1]; st = q[0] || rem != 0;
    end else begin
      m = q >> 1; g = q[0]; st = rem != 0; e--;
    end
`ifdef FP_DIV_RNE_EN
    if (g && (st || m[0])) m++;
    if (m == (longint'(1) << 24)) begin m = m >> 1; e++; end
`endif
    f = {4'b0, g | st};
    if (e >= 255) begin
      f = 5'b00101;
`ifdef FP_DIV_RNE_EN
      r = {s, 8'hFF, 23'h0};
`else
      r = {s, 31'h7F7FFFFF};
`endif
    end else if (e <= 0) begin
      f = 5'b00011; r = {s, 31'h0};
    end else r = {s, 8'(e), m[22:0]};
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    check("in_ready_idle", in_ready, 1);
    a_operand = a; b_operand = b; in_valid = 1;
    @(posedge CLK); #1 in_valid = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge CLK); #1; lat++; end
  endtask

  task automatic finish_xfer();
    out_ready = 1;
    @(posedge CLK); #1 out_ready = 0;
    check("release_ready", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [4:0] ef, input int el, input int hold);
    int lat;
    issue(a, b);
    wait_out(lat);
    check({tag, "_lat"}, lat, el);
    check(tag, {exc_flags, result}, {ef, er});
    repeat (hold) @(posedge CLK);
    #1 finish_xfer();
  endtask

  function automatic logic [31:0] rnd_op();
    int k;
    logic [7:0] ex;
    k = $urandom_range(0, 19);
    ex = k == 0 ? 8'h00 : k == 1 ? 8'hFF : 8'($urandom_range(1, 254));
    return {1'($urandom), ex, (k == 1 && $urandom_range(0, 1) == 1) ? 23'h0 : 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] a, b, er;
    logic [4:0] ef;
    bit sp;
    int lat;
    repeat (2) @(posedge CLK);
    #1 check("reset_state", {in_ready, out_valid, busy, exc_flags, result}, {3'b100, 37'h0});
    @(negedge CLK) RESET = 0;
    run_exp("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b0, 28, 0);
`ifdef FP_DIV_RNE_EN
    run_exp("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28, 0);
    run_exp("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28, 0);
`else
    run_exp("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00001, 28, 0);
    run_exp("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F7FFFFF, 5'b00101, 28, 0);
`endif
    run_exp("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2, 0);
    run_exp("zero_zero", 32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 2, 0);
    run_exp("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28, 0);
    run_exp("inf_fin", 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b0, 2, 0);
    run_exp("fin_inf", 32'h40000000, 32'hFF800000, 32'h80000000, 5'b0, 2, 0);
    run_exp("nan_in", 32'hFFC00001, 32'h40000000, 32'h7FC00000, 5'b10000, 2, 0);
    run_exp("subnorm", 32'h00400000, 32'h3F800000, 32'h00000000, 5'b0, 2, 0);
    run_exp("neg_six", 32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b0, 28, 0);
    issue(32'h40C00000, 32'h40000000);
    wait_out(lat);
    check("hold_lat", lat, 28);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      a_operand = 32'h3F800000; b_operand = 32'h40400000; in_valid = 1;
      @(posedge CLK); #1;
      check("hold", {in_ready, out_valid, exc_flags, result}, {2'b01, 5'b0, 32'h40400000});
    end
    in_valid = 0;
    finish_xfer();
    repeat (3) @(posedge CLK);
    #1 check("ignored_in", {in_ready, out_valid}, 2'b10);
    issue(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge CLK);
    @(negedge CLK) RESET = 1;
    @(posedge CLK); #1;
    check("abort", {in_ready, out_valid, busy}, 3'b100);
    @(negedge CLK) RESET = 0;
    run_exp("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b0, 28, 0);
    for (int i = 0; i < 200; i++) begin
      a = rnd_op();
      b = rnd_op();
      model(a, b, er, ef, sp);
      run_exp("rand", a, b, er, ef, sp ? 2 : 28, $urandom_range(0, 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
